calc2_core: RTL and testbench

- Four-port 32-bit integer calculator.
- Each requester port issues tagged add/sub/shift commands with two operands.
- The core queues commands per port, executes them through one shared arithmetic engine in round-robin order, and returns a tagged response on that port's output lane.
- Sits behind the calc2_bus interface as the DUT of the calculator verification environment.

---
 rtl/calc2_pkg.sv | 68 ++++++
 rtl/calc2_port_queue.sv | 95 +++++++++
 rtl/calc2_core.sv | 125 ++++++++++++
 tb/tb_calc2_core.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
// Shared widths, command/response encodings, request record and the ALU function
// for the four-port calculator core.
package calc2_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int DATA_W     = 32;
  localparam int TAG_W      = 2;
  localparam int CMD_W      = 4;
  localparam int RESP_W     = 2;
  localparam int PORT_W     = $clog2(NUM_PORTS);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic {
    CAP_IDLE,
    CAP_OP2
  } cap_state_e;

  // cmd is kept as raw bits: invalid encodings are queued and answered with an error.
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } req_t;

  typedef struct packed {
    resp_e             resp;
    logic [DATA_W-1:0] data;
  } result_t;

  function automatic result_t alu(input req_t r);
    result_t       res;
    logic [DATA_W:0] sum;
    res.resp = RESP_OK;
    res.data = '0;
    sum      = {1'b0, r.op1} + {1'b0, r.op2};
    case (r.cmd)
      CMD_ADD: begin
        if (sum[DATA_W]) res.resp = RESP_ERR;
        else             res.data = sum[DATA_W-1:0];
      end
      CMD_SUB: begin
        if (r.op2 > r.op1) res.resp = RESP_ERR;
        else               res.data = r.op1 - r.op2;
      end
      CMD_SHL: res.data = r.op1 << r.op2[4:0];
      CMD_SHR: res.data = r.op1 >> r.op2[4:0];
      default: res.resp = RESP_ERR;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/calc2_port_queue.sv
// Per-port two-cycle command capture (cmd/tag/op1, then op2) feeding a 4-deep FIFO.
// Entry is visible at the head the cycle after op2; a push into a full FIFO is dropped.
module calc2_port_queue
  import calc2_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] data,
  input  logic [TAG_W-1:0]  tag,
  input  logic              pop,
  output req_t              head,
  output logic              empty
);

  cap_state_e state, state_nxt;
  logic       capture;
  logic       push;

  logic [CMD_W-1:0]  cmd_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] op1_q;

  req_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CAP_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    push      = 1'b0;
    case (state)
      CAP_IDLE: begin
        if (cmd != CMD_NOP) begin
          capture   = 1'b1;
          state_nxt = CAP_OP2;
        end
      end
      CAP_OP2: begin
        push      = 1'b1;
        state_nxt = CAP_IDLE;
      end
      default: state_nxt = CAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
      tag_q <= '0;
      op1_q <= '0;
    end else if (capture) begin
      cmd_q <= cmd;
      tag_q <= tag;
      op1_q <= data;
    end
  end

  assign full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign head  = mem[rd_ptr];

  // op2 goes straight from the bus into the entry, so no op2 register is needed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {cmd_q, tag_q, op1_q, data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/calc2_core.sv
// Four-port calculator: per-port queues, round-robin pick of one head per cycle,
// ALU result registered onto that port's lane for exactly one cycle.
module calc2_core
  import calc2_pkg::*;
(
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [1:0]  req1_tag_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [1:0]  req2_tag_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [1:0]  req3_tag_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  input  logic [1:0]  req4_tag_in,
  output logic [31:0] out_data1,
  output logic [1:0]  out_resp1,
  output logic [1:0]  out_tag1,
  output logic [31:0] out_data2,
  output logic [1:0]  out_resp2,
  output logic [1:0]  out_tag2,
  output logic [31:0] out_data3,
  output logic [1:0]  out_resp3,
  output logic [1:0]  out_tag3,
  output logic [31:0] out_data4,
  output logic [1:0]  out_resp4,
  output logic [1:0]  out_tag4,
  input  logic        a_clk,
  input  logic        b_clk,
  input  logic        scan_in,
  output logic        scan_out
);

  logic [CMD_W-1:0]  cmd_in  [NUM_PORTS];
  logic [DATA_W-1:0] data_in [NUM_PORTS];
  logic [TAG_W-1:0]  tag_in  [NUM_PORTS];

  req_t                 head [NUM_PORTS];
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] pop;

  logic [PORT_W-1:0] last_q;
  logic [PORT_W-1:0] grant_idx;
  logic [PORT_W-1:0] idx;
  logic              grant_vld;
  result_t           result;

  logic [RESP_W-1:0] resp_q [NUM_PORTS];
  logic [DATA_W-1:0] data_q [NUM_PORTS];
  logic [TAG_W-1:0]  tag_q  [NUM_PORTS];

  logic unused_scan;

  assign cmd_in[0] = req1_cmd_in;  assign data_in[0] = req1_data_in;  assign tag_in[0] = req1_tag_in;
  assign cmd_in[1] = req2_cmd_in;  assign data_in[1] = req2_data_in;  assign tag_in[1] = req2_tag_in;
  assign cmd_in[2] = req3_cmd_in;  assign data_in[2] = req3_data_in;  assign tag_in[2] = req3_tag_in;
  assign cmd_in[3] = req4_cmd_in;  assign data_in[3] = req4_data_in;  assign tag_in[3] = req4_tag_in;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    calc2_port_queue u_queue (
      .clk   (c_clk),
      .rst_n (reset),
      .cmd   (cmd_in[g]),
      .data  (data_in[g]),
      .tag   (tag_in[g]),
      .pop   (pop[g]),
      .head  (head[g]),
      .empty (empty[g])
    );
    assign pop[g] = grant_vld && (grant_idx == PORT_W'(g));
  end

  // Search starts one past the last served port and wraps back to it last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_q;
    idx       = last_q;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = last_q + PORT_W'(i);
      if (!grant_vld && !empty[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign result = alu(head[grant_idx]);

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      last_q <= PORT_W'(NUM_PORTS - 1);
      for (int i = 0; i < NUM_PORTS; i++) begin
        resp_q[i] <= '0;
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      if (grant_vld) last_q <= grant_idx;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (pop[i]) begin
          resp_q[i] <= result.resp;
          data_q[i] <= result.data;
          tag_q[i]  <= head[i].tag;
        end else begin
          resp_q[i] <= '0;
          data_q[i] <= '0;
          tag_q[i]  <= '0;
        end
      end
    end
  end

  assign out_resp1 = resp_q[0];  assign out_data1 = data_q[0];  assign out_tag1 = tag_q[0];
  assign out_resp2 = resp_q[1];  assign out_data2 = data_q[1];  assign out_tag2 = tag_q[1];
  assign out_resp3 = resp_q[2];  assign out_data3 = data_q[2];  assign out_tag3 = tag_q[2];
  assign out_resp4 = resp_q[3];  assign out_data4 = data_q[3];  assign out_tag4 = tag_q[3];

  assign scan_out    = 1'b0;
  assign unused_scan = a_clk ^ b_clk ^ scan_in;

endmodule

// File: tb/tb_calc2_core.sv
// Bench for calc2_core: vector table plus multi-cycle sequences, checked by a
// per-port scoreboard that also pins the arrival cycle of each response.
module tb_calc2_core;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cmd_d  [4];
  logic [31:0] data_d [4];
  logic [1:0]  tag_d  [4];
  logic [31:0] data_o [4];
  logic [1:0]  resp_o [4];
  logic [1:0]  tag_o  [4];
  logic        scan_o;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    int          cyc;
  } exp_t;

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [1:0]  tag;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  exp_t sb [4][$];
  exp_t mon_e;
  vec_t vecs [13];
  int   cyc;
  int   vectors;
  int   miscompares;
  bit   end_req;
  bit   end_done;
  int   c0;

  calc2_core dut (
    .c_clk        (clk),
    .reset        (rst_n),
    .req1_cmd_in  (cmd_d[0]), .req1_data_in (data_d[0]), .req1_tag_in (tag_d[0]),
    .req2_cmd_in  (cmd_d[1]), .req2_data_in (data_d[1]), .req2_tag_in (tag_d[1]),
    .req3_cmd_in  (cmd_d[2]), .req3_data_in (data_d[2]), .req3_tag_in (tag_d[2]),
    .req4_cmd_in  (cmd_d[3]), .req4_data_in (data_d[3]), .req4_tag_in (tag_d[3]),
    .out_data1    (data_o[0]), .out_resp1 (resp_o[0]), .out_tag1 (tag_o[0]),
    .out_data2    (data_o[1]), .out_resp2 (resp_o[1]), .out_tag2 (tag_o[1]),
    .out_data3    (data_o[2]), .out_resp3 (resp_o[2]), .out_tag3 (tag_o[2]),
    .out_data4    (data_o[3]), .out_resp4 (resp_o[3]), .out_tag4 (tag_o[3]),
    .a_clk        (1'b0),
    .b_clk        (1'b0),
    .scan_in      (1'b0),
    .scan_out     (scan_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  // Sole writer of the counters: checks every lane on every falling edge.
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (!rst_n) begin
        vectors++;
        if (resp_o[p] != 2'd0 || data_o[p] != 32'd0 || tag_o[p] != 2'd0) begin
          miscompares++;
          $display("FAIL reset_out port%0d: got resp=%0d data=%h tag=%0d, want all 0",
                   p + 1, resp_o[p], data_o[p], tag_o[p]);
        end
      end else if (resp_o[p] != 2'd0) begin
        vectors++;
        if (sb[p].size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rsp port%0d cyc=%0d: got resp=%0d data=%h tag=%0d, want no response",
                   p + 1, cyc, resp_o[p], data_o[p], tag_o[p]);
        end else begin
          mon_e = sb[p].pop_front();
          if (resp_o[p] != mon_e.resp || data_o[p] != mon_e.data ||
              tag_o[p] != mon_e.tag || cyc != mon_e.cyc) begin
            miscompares++;
            $display("FAIL rsp port%0d: got resp=%0d data=%h tag=%0d cyc=%0d, want resp=%0d data=%h tag=%0d cyc=%0d",
                     p + 1, resp_o[p], data_o[p], tag_o[p], cyc,
                     mon_e.resp, mon_e.data, mon_e.tag, mon_e.cyc);
          end
        end
      end else if (data_o[p] != 32'd0 || tag_o[p] != 2'd0) begin
        miscompares++;
        $display("FAIL idle_lane port%0d cyc=%0d: got data=%h tag=%0d, want 0 with resp 0",
                 p + 1, cyc, data_o[p], tag_o[p]);
      end
    end
    if (end_req && !end_done) begin
      for (int p = 0; p < 4; p++) begin
        while (sb[p].size() != 0) begin
          mon_e = sb[p].pop_front();
          vectors++;
          miscompares++;
          $display("FAIL missing_rsp port%0d: got nothing, want resp=%0d data=%h tag=%0d cyc=%0d",
                   p + 1, mon_e.resp, mon_e.data, mon_e.tag, mon_e.cyc);
        end
      end
      end_done = 1'b1;
    end
  end

  task automatic expect_rsp(input int p, input logic [1:0] r, input logic [31:0] d,
                            input logic [1:0] t, input int at);
    exp_t e;
    e.resp = r; e.data = d; e.tag = t; e.cyc = at;
    sb[p].push_back(e);
  endtask

  // Called just after a rising edge; leaves the port free for a new command two cycles later.
  task automatic issue(input int p, input logic [3:0] cmd, input logic [1:0] tag,
                       input logic [31:0] op1, input logic [31:0] op2,
                       input logic [1:0] r, input logic [31:0] d);
    cmd_d[p] = cmd; tag_d[p] = tag; data_d[p] = op1;
    expect_rsp(p, r, d, tag, cyc + 3);
    @(posedge clk); #1;
    cmd_d[p] = 4'd1; tag_d[p] = 2'd0; data_d[p] = op2;
    @(posedge clk); #1;
    cmd_d[p] = 4'd0; data_d[p] = 32'd0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; end_req = 1'b0; end_done = 1'b0;
    for (int p = 0; p < 4; p++) begin
      cmd_d[p] = 4'd0; data_d[p] = 32'd0; tag_d[p] = 2'd0;
    end

    vecs[0]  = '{0, 4'd1, 2'd2, 32'h10,         32'h20,         2'd1, 32'h30};
    vecs[1]  = '{2, 4'd1, 2'd0, 32'hFFFF_FFFF,  32'h1,          2'd2, 32'h0};
    vecs[2]  = '{2, 4'd1, 2'd3, 32'hFFFF_FFFF,  32'h0,          2'd1, 32'hFFFF_FFFF};
    vecs[3]  = '{1, 4'd2, 2'd1, 32'h3,          32'h5,          2'd2, 32'h0};
    vecs[4]  = '{1, 4'd2, 2'd2, 32'h5,          32'h3,          2'd1, 32'h2};
    vecs[5]  = '{1, 4'd2, 2'd0, 32'h5,          32'h5,          2'd1, 32'h0};
    vecs[6]  = '{3, 4'd5, 2'd1, 32'h1,          32'h21,         2'd1, 32'h2};
    vecs[7]  = '{3, 4'd6, 2'd2, 32'h8000_0000,  32'd31,         2'd1, 32'h1};
    vecs[8]  = '{3, 4'd5, 2'd3, 32'h1234_5678,  32'h0,          2'd1, 32'h1234_5678};
    vecs[9]  = '{0, 4'd7, 2'd1, 32'h55,         32'h66,         2'd2, 32'h0};
    vecs[10] = '{2, 4'd5, 2'd2, 32'h1,          32'd31,         2'd1, 32'h8000_0000};
    vecs[11] = '{1, 4'd3, 2'd3, 32'h9,          32'h1,          2'd2, 32'h0};
    vecs[12] = '{0, 4'd1, 2'd0, 32'h7FFF_FFFF,  32'h8000_0001,  2'd2, 32'h0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      issue(vecs[i].port, vecs[i].cmd, vecs[i].tag, vecs[i].op1, vecs[i].op2,
            vecs[i].resp, vecs[i].data);
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-to-back on port 1: results must come back in issue order.
    for (int k = 0; k < 4; k++)
      issue(0, 4'd1, 2'(k), 32'(k * 7), 32'd1000, 2'd1, 32'(k * 7 + 1000));
    repeat (4) @(posedge clk);
    #1;

    // Reset with entries queued on every port: none of them may answer.
    for (int p = 0; p < 4; p++) begin
      cmd_d[p] = 4'd1; tag_d[p] = 2'(p); data_d[p] = 32'(p);
    end
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++) begin cmd_d[p] = 4'd0; data_d[p] = 32'd9; end
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++) data_d[p] = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // All ports at once right after reset: order 1,2,3,4 on consecutive cycles.
    c0 = cyc;
    for (int p = 0; p < 4; p++) begin
      cmd_d[p] = 4'd1; tag_d[p] = 2'(3 - p); data_d[p] = 32'(p + 1);
      expect_rsp(p, 2'd1, 32'(p + 1 + 256 * p), 2'(3 - p), c0 + 3 + p);
    end
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++) begin cmd_d[p] = 4'd0; data_d[p] = 32'(256 * p); end
    @(posedge clk); #1;
    for (int p = 0; p < 4; p++) data_d[p] = 32'd0;
    repeat (8) @(posedge clk);
    #1;

    end_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
